// File: rtl/alu_muldiv_pkg.sv
// Shared EX-stage definitions: ALU and mul/div op encodings,
// mul/div FSM state encoding and default datapath width.
package alu_muldiv_pkg;

    localparam int MD_WIDTH = 32;

    // ALU op encodings (combinational ALU beside the mul/div unit)
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_SLT = 4'd9;

    // mul/div op encodings
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // mul/div FSM states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // Per-operation context captured at launch
    typedef struct packed {
        logic is_div;
        logic sa;
        logic sb;
    } md_ctx_t;

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational mul/div iteration on the {upper, lower} accumulator.
// Ports: acc (current), opnd (multiplicand/divisor), is_div, acc_next.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  acc,
    input  logic [WIDTH-1:0]  opnd,
    input  logic              is_div,
    output logic [2*WIDTH:0]  acc_next
);

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] sh;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum      = '0;
        sh       = '0;
        diff     = '0;
        acc_next = acc;
        if (is_div) begin
            // Restoring divide: shift left, trial-subtract divisor
            // from the partial remainder, keep it if no borrow.
            sh   = {acc[2*WIDTH-1:0], 1'b0};
            diff = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, opnd};
            if (!diff[WIDTH+1]) begin
                acc_next = {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};
            end else begin
                acc_next = sh;
            end
        end else begin
            // Shift-add: add multiplicand when the multiplier LSB
            // is set, then shift the whole accumulator right.
            sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
            acc_next = {1'b0, sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit owning HI/LO (MULT/MULTU/DIV/DIVU).
// Ports: clk, reset, start/op/A/B launch, abort, wr_hi/wr_lo/wdata, busy, done, HI, LO.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             abort,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2*WIDTH:0] acc;
    logic [2*WIDTH:0] acc_next;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] raw_a;
    md_ctx_t          ctx;

    logic             sgn;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign busy = (state != S_IDLE);

    // Launch-time operand magnitudes
    always_comb begin
        sgn   = md_is_signed(op);
        neg_a = sgn & A[WIDTH-1];
        neg_b = sgn & B[WIDTH-1];
        mag_a = neg_a ? -A : A;
        mag_b = neg_b ? -B : B;
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc),
        .opnd    (opnd),
        .is_div  (ctx.is_div),
        .acc_next(acc_next)
    );

    // Sign fix-up; divide by zero bypasses the iterative result
    always_comb begin
        prod = acc[2*WIDTH-1:0];
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        if (ctx.sa ^ ctx.sb) begin
            prod = -prod;
        end
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (ctx.is_div) begin
            if (opnd == '0) begin
                res_hi = raw_a;
                res_lo = '1;
            end else begin
                res_hi = ctx.sa ? -rem : rem;
                res_lo = (ctx.sa ^ ctx.sb) ? -quo : quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            raw_a <= '0;
            ctx   <= '0;
            done  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        acc        <= {{(WIDTH+1){1'b0}}, mag_a};
                        opnd       <= mag_b;
                        raw_a      <= A;
                        ctx.is_div <= md_is_div(op);
                        ctx.sa     <= neg_a;
                        ctx.sb     <= neg_b;
                        cnt        <= '0;
                        state      <= S_CALC;
                    end else begin
                        if (wr_hi) HI <= wdata;
                        if (wr_lo) LO <= wdata;
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!abort) begin
                        HI   <= res_hi;
                        LO   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, beside the combinational ALU (adder, logic, barrel shifter).
- Takes the same forwarded rs/rt operands as the ALU. Executes MULT/MULTU/DIV/DIVU over several cycles.
- Owns the architectural HI/LO registers and serves MTHI/MTLO writes and MFHI/MFLO reads.
- The hazard unit stalls the pipeline on busy when an MFHI/MFLO or a new mul/div reaches EX.

Parameters:
- WIDTH, 32: operand width. Also the iteration count. HI/LO are each WIDTH bits.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk    in   1      rising-edge clock
- reset  in   1      synchronous, active-high reset
- start  in   1      launch the operation selected by op (sampled only in IDLE)
- op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A      in   WIDTH  rs operand (multiplicand / dividend)
- B      in   WIDTH  rt operand (multiplier / divisor)
- abort  in   1      kill the in-flight operation (exception/flush); HI/LO are left untouched
- wr_hi  in   1      MTHI write strobe
- wr_lo  in   1      MTLO write strobe
- wdata  in   WIDTH  MTHI/MTLO data
- busy   out  1      high while state != IDLE (decoded from the state register)
- done   out  1      one-cycle pulse; HI/LO are valid with the new result in the same cycle
- HI     out  WIDTH  HI register (registered output)
- LO     out  WIDTH  LO register (registered output)

Behaviour:
- Reset (synchronous, active-high): state=IDLE, HI=0, LO=0, done=0, counter=0. Reset wins over every other input, including mid-operation. The in-flight operation is discarded.
- States:
  - IDLE: start=1 latches magnitudes |A| and |B| (raw values for unsigned ops), the sign flags, the op, and the raw dividend; counter=0; go to CALC.
  - CALC: one shift-add (multiply) or one restoring subtract-shift (divide) step per edge. After the step with counter=WIDTH-1, go to FIX.
  - FIX: apply sign correction, write HI/LO, done=1, go to IDLE.
- Timing: start sampled at edge E0. Steps at edges E1..E32 (WIDTH=32). HI/LO written at E33. busy is high for 33 cycles. done is high for exactly the cycle after E33.
- MULT/MULTU: 2*WIDTH-bit product. HI gets the upper half, LO the lower half. Signed result is negated when sign(A) xor sign(B).
- DIV/DIVU: LO = quotient truncated toward zero, HI = remainder. The remainder takes the sign of the dividend.
- Divide by zero (both DIV and DIVU): LO=all ones, HI=A. No trap.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start while busy: ignored; the current operation is unaffected.
- wr_hi/wr_lo in IDLE: the register takes wdata at the next edge. Both may be asserted together.
- wr_hi/wr_lo while busy: ignored. The hazard unit guarantees this does not happen; the behaviour is still defined.
- start and wr_hi/wr_lo in the same IDLE cycle: start wins and the write is dropped.
- abort in CALC or FIX: state=IDLE at the next edge, no HI/LO update, no done. abort has priority over the FIX write. abort in IDLE has no effect and does not block start.
- done is registered, never asserted in consecutive cycles, and cleared one cycle after assertion.

Decomposition:
- Shared package (with the ALU op encodings):
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU op constants
  - state encoding S_IDLE/S_CALC/S_FIX
  - WIDTH default
- One sub-module, muldiv_step: combinational single-iteration datapath. Inputs are the partial accumulator and op class; output is the next accumulator, covering the add-shift and the subtract-compare-shift. The top module keeps the FSM, counter, sign fix-up and HI/LO.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. done exactly 34 cycles after the start cycle; busy high for 33 cycles.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MULT of the same operands -> HI=0, LO=1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- DIV A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start a MULT; in cycle 10 assert start (new ops), wr_hi=1 with wdata=0x55, and abort -> busy=0 next cycle, HI/LO keep their prior values, done never pulses.
- In IDLE: wr_hi with wdata=0xDEADBEEF -> HI=0xDEADBEEF next cycle. Then start a DIVU and assert reset in cycle 5 -> HI=LO=0, busy=0, done=0 next cycle. A new start afterwards completes normally.
